// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit (0), WIDTH data bits LSB first, stop bit (1),
// each bit held for CLKS_PER_BIT clocks. The line idles high and every output is registered.
module serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             busy,
    output logic             tx,
    output logic             done
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cyc_cnt, cyc_cnt_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             tx_n, ready_n, busy_n, done_n;

    // Next values for every register, outputs included, so nothing combinational reaches a pin.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the case leaves one unassigned and infers a latch.
        state_n   = state;
        cyc_cnt_n = cyc_cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        tx_n      = tx;
        ready_n   = ready;
        busy_n    = busy;
        done_n    = 1'b0;

        unique case (state)
            IDLE: begin
                tx_n    = 1'b1;
                ready_n = 1'b1;
                busy_n  = 1'b0;
                if (load && ready) begin
                    shreg_n   = data_in;
                    state_n   = START;
                    cyc_cnt_n = '0;
                    bit_cnt_n = '0;
                    tx_n      = 1'b0;
                    ready_n   = 1'b0;
                    busy_n    = 1'b1;
                end
            end
            START: begin
                if (cyc_cnt == CYC_LAST) begin
                    cyc_cnt_n = '0;
                    state_n   = DATA;
                    tx_n      = shreg[0];
                end else begin
                    cyc_cnt_n = cyc_cnt + CW'(1);
                end
            end
            DATA: begin
                if (cyc_cnt == CYC_LAST) begin
                    cyc_cnt_n = '0;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_n = '0;
                        state_n   = STOP;
                        tx_n      = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + BW'(1);
                        shreg_n   = shreg >> 1;
                        tx_n      = shreg_n[0];
                    end
                end else begin
                    cyc_cnt_n = cyc_cnt + CW'(1);
                end
            end
            STOP: begin
                if (cyc_cnt == CYC_LAST) begin
                    cyc_cnt_n = '0;
                    state_n   = IDLE;
                    ready_n   = 1'b1;
                    busy_n    = 1'b0;
                    done_n    = 1'b1;
                end else begin
                    cyc_cnt_n = cyc_cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cyc_cnt <= cyc_cnt_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            tx      <= tx_n;
            ready   <= ready_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: an 8-bit/4-clock instance and a 4-bit/1-clock instance,
// both compared against a frame model derived from the bit order on the line.
module tb_serial_tx;

    localparam int FA = (8 + 2) * 4;
    localparam int FB = (4 + 2) * 1;

    logic       clk = 1'b0;
    logic       reset_a, load_a, ready_a, busy_a, tx_a, done_a;
    logic [7:0] data_a;
    logic       reset_b, load_b, ready_b, busy_b, tx_b, done_b;
    logic [3:0] data_b;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .reset(reset_a), .data_in(data_a), .load(load_a),
        .ready(ready_a), .busy(busy_a), .tx(tx_a), .done(done_a)
    );

    serial_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .reset(reset_b), .data_in(data_b), .load(load_b),
        .ready(ready_b), .busy(busy_b), .tx(tx_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Line level i cycles after the accept edge: slot 0 is the start bit, slots 1..w the
    // data bits LSB first, slot w+1 the stop bit.
    function automatic logic exp_tx(input int w, input int cpb, input logic [31:0] d, input int i);
        int slot;
        slot = i / cpb;
        if (slot == 0) return 1'b0;
        if (slot <= w) return d[slot-1];
        return 1'b1;
    endfunction

    task automatic idle_check_a(input string tag);
        check({tag, "_tx"}, tx_a, 1);
        check({tag, "_ready"}, ready_a, 1);
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_done"}, done_a, 0);
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            idle_check_a("a_idle");
        end
    endtask

    // Sends d on dut_a, checks the line every cycle, scrambles data_in while busy,
    // optionally pulses load at glitch_at, holds load, or resets at abort_at.
    task automatic run_frame_a(input logic [7:0] d, input bit hold, input int glitch_at,
                               input int abort_at);
        int dones;
        dones  = 0;
        data_a = d;
        load_a = 1'b1;
        @(negedge clk);
        if (!hold) load_a = 1'b0;
        for (int i = 0; i < FA; i++) begin
            check("a_tx", tx_a, exp_tx(8, 4, d, i));
            if (i == 0) begin
                check("a_ready_accept", ready_a, 0);
                check("a_busy_accept", busy_a, 1);
            end
            if (done_a) dones++;
            if (i == abort_at) begin
                reset_a = 1'b1;
                load_a  = 1'b0;
                @(negedge clk);
                reset_a = 1'b0;
                idle_check_a("a_abort");
                return;
            end
            data_a = 8'($urandom);
            if (i == glitch_at) begin
                data_a = 8'hFF;
                load_a = 1'b1;
            end else if (!hold) begin
                load_a = 1'b0;
            end
            @(negedge clk);
        end
        check("a_done_in_frame", dones, 0);
        check("a_done_end", done_a, 1);
        check("a_ready_end", ready_a, 1);
        check("a_busy_end", busy_a, 0);
        check("a_tx_end", tx_a, 1);
    endtask

    task automatic run_frame_b(input logic [3:0] d);
        int dones;
        dones  = 0;
        data_b = d;
        load_b = 1'b1;
        @(negedge clk);
        load_b = 1'b0;
        for (int i = 0; i < FB; i++) begin
            check("b_tx", tx_b, exp_tx(4, 1, d, i));
            if (done_b) dones++;
            data_b = 4'($urandom);
            @(negedge clk);
        end
        check("b_done_in_frame", dones, 0);
        check("b_done_end", done_b, 1);
        check("b_ready_end", ready_b, 1);
        check("b_tx_end", tx_b, 1);
    endtask

    initial begin
        logic [7:0] line_a5;
        reset_a = 1'b1; load_a = 1'b0; data_a = '0;
        reset_b = 1'b1; load_b = 1'b0; data_b = '0;
        @(negedge clk);
        @(negedge clk);
        reset_a = 1'b0;
        reset_b = 1'b0;
        idle_check_a("a_reset");
        check("b_reset_tx", tx_b, 1);
        check("b_reset_ready", ready_b, 1);
        check("b_reset_busy", busy_b, 0);
        check("b_reset_done", done_b, 0);
        idle_a(10);

        // Hand-derived line for 8'hA5 sampled mid-slot, independent of the frame model.
        line_a5 = 8'b1010_0101;
        data_a  = 8'hA5;
        load_a  = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        for (int i = 0; i < FA; i++) begin
            if (i % 4 == 2)
                check("a5_slot", tx_a, (i / 4 == 0) ? 1'b0 : (i / 4 == 9) ? 1'b1 : line_a5[i/4-1]);
            @(negedge clk);
        end
        check("a5_done_at_40", done_a, 1);
        check("a5_ready_at_40", ready_a, 1);
        idle_a(3);

        run_frame_a(8'hA5, 1'b0, -1, -1);
        idle_a(3);

        // Load with 8'hFF in mid-frame must be ignored; idle_a confirms a single done pulse.
        run_frame_a(8'h00, 1'b0, 13, -1);
        idle_a(3);

        // load held high: second frame starts the cycle after done.
        run_frame_a(8'h3C, 1'b1, -1, -1);
        run_frame_a(8'hC3, 1'b0, -1, -1);
        idle_a(2);

        // Reset during data bit 3 (slot 4), then a clean frame.
        run_frame_a(8'h0F, 1'b0, -1, 16);
        idle_a(3);
        run_frame_a(8'h81, 1'b0, -1, -1);
        idle_a(2);

        // Reset and load at the same edge: nothing accepted.
        reset_a = 1'b1;
        load_a  = 1'b1;
        data_a  = 8'h55;
        @(negedge clk);
        reset_a = 1'b0;
        load_a  = 1'b0;
        idle_check_a("a_rst_load");
        idle_a(2);

        for (int n = 0; n < 6; n++) begin
            run_frame_a(8'($urandom), 1'b0, int'($urandom_range(1, FA - 2)), -1);
            if ($urandom_range(0, 1) == 1) idle_a(int'($urandom_range(1, 3)));
        end
        idle_a(2);

        run_frame_b(4'b1010);
        @(negedge clk);
        check("b_idle_done", done_b, 0);
        for (int n = 0; n < 5; n++) run_frame_b(4'($urandom));
        @(negedge clk);
        check("b_final_ready", ready_b, 1);
        check("b_final_done", done_b, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
